// File: rtl/gpu_bram_wr_arbiter.sv
// Write-port controller for a GPU block RAM: arbitrates CPU (A) and rasteriser (B)
// writes onto the single RAM write port and runs a full-memory clear engine.
module gpu_bram_wr_arbiter #(
  parameter int                    ADDR_WIDTH   = 10,
  parameter int                    SIZE         = 1024,
  parameter int                    DATA_WIDTH   = 64,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0,
  parameter int                    STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done,
  input  logic                  a_valid,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] mem_din_addr,
  output logic [DATA_WIDTH-1:0] mem_din
);

  localparam int                    STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0]   STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(SIZE - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t                state;
  logic [STARVE_W-1:0]   starve_cnt;
  logic [ADDR_WIDTH-1:0] clear_addr;
  logic                  b_priority;
  logic                  grant_window;

  // Grants are only offered in IDLE and never in the cycle a clear is requested.
  assign b_priority   = (starve_cnt == STARVE_MAX);
  assign grant_window = (state == IDLE) && !clear_start;
  assign a_ready      = grant_window && a_valid && !b_priority;
  assign b_ready      = grant_window && b_valid && (!a_valid || b_priority);
  assign clear_busy   = (state == CLEAR);

  // NOTE: reset is synchronous here, so it lives inside the clocked branch only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      we           <= 1'b0;
      mem_din_addr <= '0;
      mem_din      <= '0;
      clear_done   <= 1'b0;
      starve_cnt   <= '0;
      clear_addr   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      clear_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!b_valid || b_ready) begin
            starve_cnt <= '0;
          end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
          end

          if (clear_start) begin
            state        <= CLEAR;
            clear_addr   <= '0;
            we           <= 1'b1;
            mem_din_addr <= '0;
            mem_din      <= CLEAR_VALUE;
          end else if (a_ready) begin
            we           <= 1'b1;
            mem_din_addr <= a_addr;
            mem_din      <= a_data;
          end else if (b_ready) begin
            we           <= 1'b1;
            mem_din_addr <= b_addr;
            mem_din      <= b_data;
          end else begin
            we <= 1'b0;
          end
        end

        CLEAR: begin
          // clear_addr tracks the address currently on the port; stop after SIZE-1.
          if (clear_addr == LAST_ADDR) begin
            state      <= IDLE;
            we         <= 1'b0;
            clear_done <= 1'b1;
          end else begin
            clear_addr   <= clear_addr + 1'b1;
            mem_din_addr <= clear_addr + 1'b1;
            we           <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
